// File: rtl/aer_in_receiver.sv
// aer_in_receiver: receiving end of the on-chip 4-phase AER link.
// Completes the REQ/ACK handshake, captures the (M+2)-bit event address and
// buffers {type, neuron address} in a first-word-fall-through FIFO that the
// scheduler drains over a valid/ready port. A full FIFO withholds ACK, so
// events are never dropped.
// Optional feature macro: AER_IN_SYNC_EN adds a 2-flop synchronizer on AER_REQ_i.
module aer_in_receiver #(
  parameter int N          = 256,
  parameter int M          = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             start_i,
  input  logic [M+1:0]     AER_ADDR_i,
  input  logic             AER_REQ_i,
  output logic             AER_ACK_o,
  output logic             EVT_VALID_o,
  input  logic             EVT_READY_i,
  output logic [1:0]       EVT_TYPE_o,
  output logic [M-1:0]     EVT_ADDR_o,
  output logic             FIFO_full_o,
  output logic [CNT_W-1:0] evt_cnt_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  if (N != (1 << M)) begin : g_bad_n
    $error("aer_in_receiver: N must equal 2**M");
  end
  if ((FIFO_DEPTH < 2) || (FIFO_DEPTH != (1 << PW))) begin : g_bad_depth
    $error("aer_in_receiver: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic {IDLE, ACKED} state_t;

  logic req_s;

`ifdef AER_IN_SYNC_EN
  logic req_meta_q, req_sync_q;

  // Two-flop synchronizer for a REQ arriving from another clock domain
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      req_meta_q <= 1'b0;
      req_sync_q <= 1'b0;
    end else begin
      req_meta_q <= AER_REQ_i;
      req_sync_q <= req_meta_q;
    end
  end

  assign req_s = req_sync_q;
`else
  assign req_s = AER_REQ_i;
`endif

  state_t           state_q, state_d;
  logic             ack_q, ack_d;
  logic [M+1:0]     addr_q, addr_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_idx;
  logic             cnt_inc;
  logic             full, empty, pop, wr;
  logic [M+1:0]     mem_q [FIFO_DEPTH];
  logic [M+1:0]     head;

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign pop   = !empty && EVT_READY_i;
  // The address captured on the ACK edge lands in the FIFO one edge later,
  // which is why VALID trails ACK by one cycle. The FSM cannot re-enter IDLE
  // before that write lands, so the full flag it sees is always current.
  assign wr    = pend_q;

  // Handshake FSM, saturating event counter and FIFO pointer/occupancy update
  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    addr_d   = addr_q;
    pend_d   = 1'b0;
    cnt_inc  = 1'b0;
    cnt_d    = cnt_q;
    wr_idx   = wr_ptr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    case (state_q)
      IDLE: begin
        if (req_s && !full) begin
          state_d = ACKED;
          ack_d   = 1'b1;
          addr_d  = AER_ADDR_i;
          pend_d  = 1'b1;
          cnt_inc = 1'b1;
        end
      end
      ACKED: begin
        if (!req_s) begin
          state_d = IDLE;
          ack_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        ack_d   = 1'b0;
      end
    endcase

    // start_i keeps an event that is being pushed (or is in flight) on the
    // same edge, so counter and FIFO both restart at exactly that one event.
    if (start_i) begin
      cnt_d    = (cnt_inc || wr) ? CNT_W'(1) : '0;
      wr_idx   = '0;
      wr_ptr_d = wr ? PW'(1) : '0;
      rd_ptr_d = '0;
      count_d  = wr ? CW'(1) : '0;
    end else begin
      if (cnt_inc && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      wr_ptr_d = wr_ptr_q + PW'(wr);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CW'(wr) - CW'(pop);
    end
  end

  // All control state; reset drops ACK asynchronously and empties the FIFO
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      addr_q   <= '0;
      pend_q   <= 1'b0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      addr_q   <= addr_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are meaningful only where occupancy covers them
  always_ff @(posedge CLK) begin
    if (wr) begin
      mem_q[wr_idx] <= addr_q;
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign AER_ACK_o   = ack_q;
  assign EVT_VALID_o = !empty;
  assign EVT_TYPE_o  = empty ? '0 : head[M+1:M];
  assign EVT_ADDR_o  = empty ? '0 : head[M-1:0];
  assign FIFO_full_o = full;
  assign evt_cnt_o   = cnt_q;

endmodule

// File: tb/tb_aer_in_receiver.sv
// Directed self-checking bench for aer_in_receiver (M=8, FIFO_DEPTH=4).
// Latency expectations follow AER_IN_SYNC_EN when it is defined.
module tb_aer_in_receiver;

  localparam int M     = 8;
  localparam int CNT_W = 16;
`ifdef AER_IN_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic             CLK = 1'b0;
  logic             RSTN;
  logic             start_i;
  logic [M+1:0]     AER_ADDR_i;
  logic             AER_REQ_i;
  logic             AER_ACK_o;
  logic             EVT_VALID_o;
  logic             EVT_READY_i;
  logic [1:0]       EVT_TYPE_o;
  logic [M-1:0]     EVT_ADDR_o;
  logic             FIFO_full_o;
  logic [CNT_W-1:0] evt_cnt_o;

  int n_cmp  = 0;
  int n_fail = 0;

  aer_in_receiver #(.N(256), .M(M), .FIFO_DEPTH(4), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RSTN(RSTN), .start_i(start_i),
    .AER_ADDR_i(AER_ADDR_i), .AER_REQ_i(AER_REQ_i), .AER_ACK_o(AER_ACK_o),
    .EVT_VALID_o(EVT_VALID_o), .EVT_READY_i(EVT_READY_i),
    .EVT_TYPE_o(EVT_TYPE_o), .EVT_ADDR_o(EVT_ADDR_o),
    .FIFO_full_o(FIFO_full_o), .evt_cnt_o(evt_cnt_o)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Bounded wait for ACK to reach a level; an expired bound fails the check
  task automatic wait_ack(input string tag, input logic v);
    for (int i = 0; i < 20; i++) begin
      if (AER_ACK_o === v) break;
      tick();
    end
    chk(tag, 32'(AER_ACK_o), 32'(v));
  endtask

  task automatic send(input logic [M+1:0] a, input string tag);
    AER_ADDR_i = a;
    AER_REQ_i  = 1'b1;
    wait_ack(tag, 1'b1);
    AER_REQ_i  = 1'b0;
    wait_ack(tag, 1'b0);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  initial begin
    RSTN = 1'b0; start_i = 1'b0; AER_ADDR_i = '0; AER_REQ_i = 1'b0; EVT_READY_i = 1'b0;
    #1;
    chk("rst_ack",   32'(AER_ACK_o),   32'h0);
    chk("rst_valid", 32'(EVT_VALID_o), 32'h0);
    chk("rst_type",  32'(EVT_TYPE_o),  32'h0);
    chk("rst_addr",  32'(EVT_ADDR_o),  32'h0);
    chk("rst_full",  32'(FIFO_full_o), 32'h0);
    chk("rst_cnt",   32'(evt_cnt_o),   32'h0);
    tick(); tick();
    RSTN = 1'b1;
    tick();

    // Single event: ACK after E(L), VALID after E(L+1)
    AER_ADDR_i = 10'h2A5;
    AER_REQ_i  = 1'b1;
    repeat (L) tick();
    chk("single_ack_early", 32'(AER_ACK_o), 32'h0);
    tick();
    chk("single_ack_rise", 32'(AER_ACK_o), 32'h1);
    chk("single_valid_early", 32'(EVT_VALID_o), 32'h0);
    tick();
    chk("single_valid", 32'(EVT_VALID_o), 32'h1);
    chk("single_type",  32'(EVT_TYPE_o),  32'h2);
    chk("single_addr",  32'(EVT_ADDR_o),  32'hA5);
    chk("single_cnt",   32'(evt_cnt_o),   32'h1);
    AER_REQ_i = 1'b0;
    repeat (L) tick();
    chk("single_ack_hold", 32'(AER_ACK_o), 32'h1);
    tick();
    chk("single_ack_fall", 32'(AER_ACK_o), 32'h0);
    EVT_READY_i = 1'b1;
    tick();
    EVT_READY_i = 1'b0;
    chk("single_popped", 32'(EVT_VALID_o), 32'h0);

    // Long REQ: one event only
    pulse_start();
    chk("start_cnt_clear", 32'(evt_cnt_o), 32'h0);
    AER_ADDR_i = 10'h155;
    AER_REQ_i  = 1'b1;
    repeat (20) tick();
    chk("long_cnt", 32'(evt_cnt_o), 32'h1);
    AER_REQ_i = 1'b0;
    wait_ack("long_ack_fall", 1'b0);
    repeat (3) tick();
    chk("long_cnt_after", 32'(evt_cnt_o), 32'h1);
    chk("long_addr", 32'(EVT_ADDR_o), 32'h55);
    chk("long_type", 32'(EVT_TYPE_o), 32'h1);
    EVT_READY_i = 1'b1;
    tick();
    EVT_READY_i = 1'b0;
    chk("long_single_entry", 32'(EVT_VALID_o), 32'h0);

    // Back-pressure: 4 accepted, 5th held until space frees
    pulse_start();
    for (int i = 1; i <= 4; i++) send(10'(i), "bp_fill");
    tick();
    chk("bp_full", 32'(FIFO_full_o), 32'h1);
    AER_ADDR_i = 10'h005;
    AER_REQ_i  = 1'b1;
    repeat (10) tick();
    chk("bp_ack_withheld", 32'(AER_ACK_o), 32'h0);
    chk("bp_cnt4", 32'(evt_cnt_o), 32'h4);
    chk("bp_head1", 32'(EVT_ADDR_o), 32'h1);
    EVT_READY_i = 1'b1;
    tick();
    EVT_READY_i = 1'b0;
    chk("bp_no_push_on_pop_edge", 32'(AER_ACK_o), 32'h0);
    chk("bp_not_full", 32'(FIFO_full_o), 32'h0);
    tick();
    chk("bp_ack_next", 32'(AER_ACK_o), 32'h1);
    tick();
    chk("bp_full_again", 32'(FIFO_full_o), 32'h1);
    AER_REQ_i = 1'b0;
    wait_ack("bp_ack_fall", 1'b0);
    EVT_READY_i = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      chk("bp_drain_valid", 32'(EVT_VALID_o), 32'h1);
      chk("bp_drain_addr", 32'(EVT_ADDR_o), 32'(i));
      tick();
    end
    EVT_READY_i = 1'b0;
    chk("bp_drained", 32'(EVT_VALID_o), 32'h0);
    chk("bp_cnt5", 32'(evt_cnt_o), 32'h5);

    // Simultaneous push/pop at occupancy 2 across pointer wrap
    send(10'h010, "pp_pre");
    send(10'h011, "pp_pre");
    for (int k = 0; k < 8; k++) begin
      AER_ADDR_i = 10'(32'h20 + k);
      AER_REQ_i  = 1'b1;
      wait_ack("pp_ack", 1'b1);
      chk("pp_head", 32'(EVT_ADDR_o), (k < 2) ? 32'h10 + 32'(k) : 32'h20 + 32'(k - 2));
      EVT_READY_i = 1'b1;
      tick();
      EVT_READY_i = 1'b0;
      chk("pp_full", 32'(FIFO_full_o), 32'h0);
      AER_REQ_i = 1'b0;
      wait_ack("pp_ack_fall", 1'b0);
    end
    EVT_READY_i = 1'b1;
    chk("pp_rem0", 32'(EVT_ADDR_o), 32'h26);
    tick();
    chk("pp_rem1", 32'(EVT_ADDR_o), 32'h27);
    tick();
    EVT_READY_i = 1'b0;
    chk("pp_empty", 32'(EVT_VALID_o), 32'h0);

    // start_i on the push edge with 3 entries queued
    for (int i = 0; i < 3; i++) send(10'(32'h31 + i), "st_fill");
    AER_ADDR_i = 10'h3C4;
    AER_REQ_i  = 1'b1;
    repeat (L) tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("st_ack", 32'(AER_ACK_o), 32'h1);
    tick();
    chk("st_valid", 32'(EVT_VALID_o), 32'h1);
    chk("st_type", 32'(EVT_TYPE_o), 32'h3);
    chk("st_addr", 32'(EVT_ADDR_o), 32'hC4);
    chk("st_cnt", 32'(evt_cnt_o), 32'h1);
    EVT_READY_i = 1'b1;
    tick();
    EVT_READY_i = 1'b0;
    chk("st_only_one", 32'(EVT_VALID_o), 32'h0);
    AER_REQ_i = 1'b0;
    wait_ack("st_ack_fall", 1'b0);

    // Reset mid-handshake, REQ still high afterwards
    AER_ADDR_i = 10'h0F7;
    AER_REQ_i  = 1'b1;
    wait_ack("rm_ack", 1'b1);
    tick();
    chk("rm_valid_pre", 32'(EVT_VALID_o), 32'h1);
    #2 RSTN = 1'b0;
    #1;
    chk("rm_ack_async", 32'(AER_ACK_o), 32'h0);
    chk("rm_valid_async", 32'(EVT_VALID_o), 32'h0);
    #1 RSTN = 1'b1;
    wait_ack("rm_ack_again", 1'b1);
    tick();
    chk("rm_valid", 32'(EVT_VALID_o), 32'h1);
    chk("rm_addr", 32'(EVT_ADDR_o), 32'hF7);
    chk("rm_cnt", 32'(evt_cnt_o), 32'h1);
    AER_REQ_i = 1'b0;
    wait_ack("rm_ack_fall", 1'b0);
    EVT_READY_i = 1'b1;
    tick();
    EVT_READY_i = 1'b0;
    chk("rm_one_event", 32'(EVT_VALID_o), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
